// File: rtl/timer_controller.sv
// timer_controller: free-running 64-bit microsecond timer with APB access and
// CHANNELS compare channels, each raising a registered interrupt.
//   clk, nreset            : clock, async active-low reset
//   apb_P*                 : APB slave (PREADY tied high, PRDATA combinational)
//   utime                  : microsecond counter
//   irq[CHANNELS-1:0]      : per-channel interrupt
// Build option: define TIMER_PERIODIC_EN to add periodic auto-reload channels
// (CTRL bit1, PERIOD register, sticky pending bits cleared by W1C IRQ_STATUS).

// One compare channel: CMP/CTRL/PERIOD storage, 2-stage compare pipeline, irq.
module timer_channel (
  input  logic        clk,
  input  logic        nreset,
  input  logic [63:0] utime_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_per_i,
  input  logic        w1c_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cmp_o,
  output logic        en_o,
  output logic        per_o,
  output logic [31:0] period_o,
  output logic        irq_o
);
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        hi_gt_q, hi_eq_q, lo_ge_q;
  logic        match_q, match_d;
  logic        irq_q, irq_d;
  logic        per_q;
  logic [31:0] period_q;
  logic        reload;

  assign match_d = hi_gt_q | (hi_eq_q & lo_ge_q);
  assign en_d    = wr_ctrl_i ? wdata_i[0] : en_q;

`ifdef TIMER_PERIODIC_EN
  logic per_d, rise_q, pending_q, pending_d;
  assign per_d     = wr_ctrl_i ? wdata_i[1] : per_q;
  // Reload one clock after match rises; PERIOD of zero never reloads.
  assign reload    = rise_q & en_q & per_q & (period_q != '0);
  // A new set beats a same-cycle W1C clear.
  assign pending_d = (match_d & ~match_q & en_q & per_q) | (pending_q & ~w1c_i);
  assign irq_d     = en_d & (per_d ? pending_d : match_d);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      per_q     <= 1'b0;
      period_q  <= '0;
      rise_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      per_q     <= per_d;
      if (wr_per_i) period_q <= wdata_i;
      rise_q    <= match_d & ~match_q;
      pending_q <= pending_d;
    end
  end
`else
  // match_q only feeds edge detection in periodic builds.
  logic unused_cfg;
  assign unused_cfg = ^{wr_per_i, w1c_i, match_q};
  assign per_q      = 1'b0;
  assign period_q   = '0;
  assign reload     = 1'b0;
  assign irq_d      = en_d & match_d;
`endif

  // Software writes to either CMP half discard a same-cycle reload entirely.
  always_comb begin
    cmp_d = cmp_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cmp_d[31:0]  = wdata_i;
      if (wr_hi_i) cmp_d[63:32] = wdata_i;
    end else if (reload) begin
      cmp_d = cmp_q + {32'h0, period_q};
    end
  end

  // irq_q is computed from next-state enable so that it tracks en & match
  // with the 2-clock compare latency and drops the clock after disable.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cmp_q   <= '1;
      en_q    <= 1'b0;
      hi_gt_q <= 1'b0;
      hi_eq_q <= 1'b0;
      lo_ge_q <= 1'b0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      hi_gt_q <= utime_i[63:32] >  cmp_q[63:32];
      hi_eq_q <= utime_i[63:32] == cmp_q[63:32];
      lo_ge_q <= utime_i[31:0]  >= cmp_q[31:0];
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end

  assign cmp_o    = cmp_q;
  assign en_o     = en_q;
  assign per_o    = per_q;
  assign period_o = period_q;
  assign irq_o    = irq_q;
endmodule

module timer_controller #(
  parameter int CLK_FREQ = 48_000_000,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [7:0]          apb_PADDR,
  input  logic                apb_PSEL,
  input  logic                apb_PENABLE,
  input  logic                apb_PWRITE,
  input  logic [31:0]         apb_PWDATA,
  output logic [31:0]         apb_PRDATA,
  output logic                apb_PREADY,
  output logic [63:0]         utime,
  output logic [CHANNELS-1:0] irq
);
  localparam int DIV = CLK_FREQ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]              pre_q;
  logic [63:0]                utime_q;
  logic [31:0]                snap_q;
  logic [5:0]                 widx;
  logic                       wr, rd_lo, w1c;
  logic [CHANNELS-1:0][63:0]  cmp;
  logic [CHANNELS-1:0][31:0]  period;
  logic [CHANNELS-1:0]        en, per;
  logic                       unused_addr;

  assign widx        = apb_PADDR[7:2];
  assign unused_addr = ^apb_PADDR[1:0];
  assign wr          = apb_PSEL & apb_PENABLE & apb_PWRITE;
  assign rd_lo       = apb_PSEL & apb_PENABLE & ~apb_PWRITE & (widx == 6'd0);
  assign w1c         = wr & (widx == 6'd2);
  assign apb_PREADY  = 1'b1;
  assign utime       = utime_q;

  // Reading UTIME_LO captures the upper word so UTIME_HI is tear-free.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pre_q   <= '0;
      utime_q <= '0;
      snap_q  <= '0;
    end else begin
      if (pre_q == PW'(DIV - 1)) begin
        pre_q   <= '0;
        utime_q <= utime_q + 64'd1;
      end else begin
        pre_q   <= pre_q + 1'b1;
      end
      if (rd_lo) snap_q <= utime_q[63:32];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [5:0] BASE = 6'(8 + 4 * g);
    timer_channel u_ch (
      .clk       (clk),
      .nreset    (nreset),
      .utime_i   (utime_q),
      .wr_lo_i   (wr & (widx == BASE)),
      .wr_hi_i   (wr & (widx == BASE + 6'd1)),
      .wr_ctrl_i (wr & (widx == BASE + 6'd2)),
      .wr_per_i  (wr & (widx == BASE + 6'd3)),
      .w1c_i     (w1c & apb_PWDATA[g]),
      .wdata_i   (apb_PWDATA),
      .cmp_o     (cmp[g]),
      .en_o      (en[g]),
      .per_o     (per[g]),
      .period_o  (period[g]),
      .irq_o     (irq[g])
    );
  end

  always_comb begin
    apb_PRDATA = '0;
    case (widx)
      6'd0:    apb_PRDATA = utime_q[31:0];
      6'd1:    apb_PRDATA = snap_q;
      6'd2:    apb_PRDATA = 32'(irq);
      default: apb_PRDATA = '0;
    endcase
    for (int n = 0; n < CHANNELS; n++) begin
      if (widx == 6'(8 + 4 * n))  apb_PRDATA = cmp[n][31:0];
      if (widx == 6'(9 + 4 * n))  apb_PRDATA = cmp[n][63:32];
      if (widx == 6'(10 + 4 * n)) apb_PRDATA = {30'h0, per[n], en[n]};
      if (widx == 6'(11 + 4 * n)) apb_PRDATA = period[n];
    end
  end
endmodule
